// File: rtl/jk_bank_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_bank_sched_if : requester command bus and JK-bank link for jk_bank_sched |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface jk_bank_sched_if #(
   parameter int NREQ = 4,
   parameter int NFF  = 8,
   parameter int IDXW = 4,
   parameter int REQW = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [2*NREQ-1:0]    req_op;
   logic [IDXW*NREQ-1:0] req_idx;
   logic [NREQ-1:0]      req_ready;
   logic [NFF-1:0]       bank_j;
   logic [NFF-1:0]       bank_k;
   logic [NFF-1:0]       bank_q;
   logic                 done_valid;
   logic [REQW-1:0]      done_req;
   logic                 done_err;

   // Control side: posts commands, owns the flop bank and consumes completions.
   modport master (
      output req_valid, req_op, req_idx, bank_q,
      input  req_ready, bank_j, bank_k, done_valid, done_req, done_err
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_op, req_idx, bank_q,
      output req_ready, bank_j, bank_k, done_valid, done_req, done_err
   );
endinterface
`default_nettype wire

// File: rtl/jk_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_bank_sched : round-robin JK command scheduler for a shared flop bank     |
// | Optional readback CHECK state enabled by defining JK_BANK_SCHED_CHECK_EN.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module jk_bank_sched #(
   parameter int NREQ = 4,
   parameter int NFF  = 8,
   parameter int IDXW = 4,
   parameter int REQW = 2
) (
   input wire             clk,
   input wire             reset,
   jk_bank_sched_if.slave bus
);

`ifdef JK_BANK_SCHED_CHECK_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [REQW-1:0]  p_q, p_d;
   logic [NFF-1:0]   bank_j_q, bank_j_d;
   logic [NFF-1:0]   bank_k_q, bank_k_d;
   logic             done_valid_q, done_valid_d;
   logic [REQW-1:0]  done_req_q, done_req_d;

`ifdef JK_BANK_SCHED_CHECK_EN
   logic [REQW-1:0]  g_q, g_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             oor_q, oor_d;
   logic             exp_q, exp_d;
   logic             w_q_sel;
`else
   logic             done_err_q, done_err_d;
`endif

   logic [NREQ-1:0]  w_rot;
   logic             w_any;
   logic [REQW:0]    w_sum;
   logic [REQW-1:0]  w_win;
   logic [1:0]       w_op;
   logic [IDXW-1:0]  w_idx;
   logic             w_oor;
   logic             w_accept;

   function automatic logic q_at(input logic [NFF-1:0] q, input logic [IDXW-1:0] idx);
      q_at = 1'b0;
      for (int k = 0; k < NFF; k++) begin
         if (idx == IDXW'(k)) q_at = q[k];
      end
   endfunction

   // Rotate valids so bit 0 is the requester at the pointer; first set bit wins.
   always_comb begin
      w_rot = NREQ'({bus.req_valid, bus.req_valid} >> p_q);
      w_any = 1'b0;
      w_sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_any && w_rot[k]) begin
            w_any = 1'b1;
            w_sum = {1'b0, p_q} + (REQW+1)'(k);
         end
      end
      if (w_sum >= (REQW+1)'(NREQ)) w_sum = w_sum - (REQW+1)'(NREQ);
      w_win = w_sum[REQW-1:0];
   end

   always_comb begin
      w_op  = '0;
      w_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == REQW'(k)) begin
            w_op  = bus.req_op[2*k +: 2];
            w_idx = bus.req_idx[IDXW*k +: IDXW];
         end
      end
   end

   assign w_oor    = ({1'b0, w_idx} >= (IDXW+1)'(NFF));
   // A cycle with reset high never completes a handshake, so ready stays low.
   assign w_accept = (state_q == S_IDLE) && w_any && !reset;
   assign bus.req_ready = w_accept ? (NREQ'(1) << w_win) : '0;

`ifdef JK_BANK_SCHED_CHECK_EN
   assign w_q_sel = q_at(bus.bank_q, w_idx);
`endif

   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      bank_j_d     = '0;
      bank_k_d     = '0;
      done_valid_d = 1'b0;
      done_req_d   = done_req_q;
`ifdef JK_BANK_SCHED_CHECK_EN
      g_d          = g_q;
      idx_d        = idx_q;
      oor_d        = oor_q;
      exp_d        = exp_q;
`else
      done_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               state_d = S_ISSUE;
               p_d     = (w_win == REQW'(NREQ-1)) ? '0 : w_win + 1'b1;
               if (!w_oor) begin
                  bank_j_d = NFF'(w_op[1]) << w_idx;
                  bank_k_d = NFF'(w_op[0]) << w_idx;
               end
`ifdef JK_BANK_SCHED_CHECK_EN
               g_d   = w_win;
               idx_d = w_idx;
               oor_d = w_oor;
               case (w_op)
                  2'b00:   exp_d = w_q_sel;
                  2'b01:   exp_d = 1'b0;
                  2'b10:   exp_d = 1'b1;
                  default: exp_d = ~w_q_sel;
               endcase
`else
               done_valid_d = 1'b1;
               done_req_d   = w_win;
               done_err_d   = w_oor;
`endif
            end
         end
         S_ISSUE: begin
`ifdef JK_BANK_SCHED_CHECK_EN
            state_d      = S_CHECK;
            done_valid_d = 1'b1;
            done_req_d   = g_q;
`else
            state_d      = S_IDLE;
`endif
         end
`ifdef JK_BANK_SCHED_CHECK_EN
         S_CHECK: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         p_q          <= '0;
         bank_j_q     <= '0;
         bank_k_q     <= '0;
         done_valid_q <= 1'b0;
         done_req_q   <= '0;
`ifdef JK_BANK_SCHED_CHECK_EN
         g_q          <= '0;
         idx_q        <= '0;
         oor_q        <= 1'b0;
         exp_q        <= 1'b0;
`else
         done_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         bank_j_q     <= bank_j_d;
         bank_k_q     <= bank_k_d;
         done_valid_q <= done_valid_d;
         done_req_q   <= done_req_d;
`ifdef JK_BANK_SCHED_CHECK_EN
         g_q          <= g_d;
         idx_q        <= idx_d;
         oor_q        <= oor_d;
         exp_q        <= exp_d;
`else
         done_err_q   <= done_err_d;
`endif
      end
   end

   assign bus.bank_j     = bank_j_q;
   assign bus.bank_k     = bank_k_q;
   assign bus.done_valid = done_valid_q;
   assign bus.done_req   = done_req_q;
`ifdef JK_BANK_SCHED_CHECK_EN
   // The bank only shows its updated Q during CHECK, so the verdict is formed live.
   assign bus.done_err   = done_valid_q & (oor_q | (q_at(bus.bank_q, idx_q) != exp_q));
`else
   assign bus.done_err   = done_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sched.sv
`default_nettype none
// tb_jk_bank_sched: directed bench for jk_bank_sched with a behavioural JK flop bank.
module tb_jk_bank_sched;
   localparam int NREQ = 4;
   localparam int NFF  = 8;
   localparam int IDXW = 4;
   localparam int REQW = 2;
`ifdef JK_BANK_SCHED_CHECK_EN
   localparam int   SPACING = 3;
   localparam logic IGN_ERR = 1'b1;
`else
   localparam int   SPACING = 2;
   localparam logic IGN_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   jk_bank_sched_if #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW), .REQW(REQW)) bus ();
   jk_bank_sched #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW), .REQW(REQW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [NFF-1:0] q_model;
   logic [NFF-1:0] ld_val = '0;
   logic           ld_en = 1'b1;
   logic           ignore_jk = 1'b0;
   int             cyc = 0;
   int             n_checks = 0;
   int             n_fail = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_en) q_model <= ld_val;
      else if (!ignore_jk) begin
         for (int i = 0; i < NFF; i++) begin
            case ({bus.bank_j[i], bus.bank_k[i]})
               2'b01:   q_model[i] <= 1'b0;
               2'b10:   q_model[i] <= 1'b1;
               2'b11:   q_model[i] <= ~q_model[i];
               default: ;
            endcase
         end
      end
   end
   assign bus.bank_q = q_model;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done();
`ifdef JK_BANK_SCHED_CHECK_EN
      step();
`endif
   endtask

   task automatic load_q(input logic [NFF-1:0] v);
      step();
      ld_val = v;
      ld_en  = 1'b1;
      step();
      ld_en  = 1'b0;
   endtask

   task automatic post(input int r, input logic [1:0] op, input logic [IDXW-1:0] idx);
      bus.req_valid[r]             = 1'b1;
      bus.req_op[2*r +: 2]         = op;
      bus.req_idx[IDXW*r +: IDXW]  = idx;
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (bus.req_ready != '0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL ready_timeout: req_ready=%b, required a grant within 12 cycles", bus.req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid = '0; bus.req_op = '0; bus.req_idx = '0;
      repeat (3) step();
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", bus.req_ready); end
      n_checks++; if (bus.bank_j !== 8'h00) begin n_fail++; $display("FAIL reset_bank_j: got %h required 00", bus.bank_j); end
      n_checks++; if (bus.bank_k !== 8'h00) begin n_fail++; $display("FAIL reset_bank_k: got %h required 00", bus.bank_k); end
      n_checks++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid: got %b required 0", bus.done_valid); end
      n_checks++; if (bus.done_req !== 2'd0) begin n_fail++; $display("FAIL reset_done_req: got %0d required 0", bus.done_req); end
      n_checks++; if (bus.done_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b required 0", bus.done_err); end
      reset = 1'b0;
      ld_en = 1'b0;
   endtask

   task automatic test_set_cmd();
      load_q(8'h00);
      post(0, 2'b10, 4'd3);
      wait_ready();
      n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL set_ready: got %b required 0001", bus.req_ready); end
      step();
      bus.req_valid = '0;
      n_checks++; if (bus.bank_j !== 8'h08) begin n_fail++; $display("FAIL set_bank_j: got %h required 08", bus.bank_j); end
      n_checks++; if (bus.bank_k !== 8'h00) begin n_fail++; $display("FAIL set_bank_k: got %h required 00", bus.bank_k); end
      wait_done();
      n_checks++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL set_done_valid: got %b required 1", bus.done_valid); end
      n_checks++; if (bus.done_req !== 2'd0) begin n_fail++; $display("FAIL set_done_req: got %0d required 0", bus.done_req); end
      n_checks++; if (bus.done_err !== 1'b0) begin n_fail++; $display("FAIL set_done_err: got %b required 0", bus.done_err); end
      step();
      n_checks++; if (q_model[3] !== 1'b1) begin n_fail++; $display("FAIL set_q3: got %b required 1", q_model[3]); end
      n_checks++; if (bus.bank_j !== 8'h00) begin n_fail++; $display("FAIL set_j_pulse: got %h required 00", bus.bank_j); end
      n_checks++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL set_done_pulse: got %b required 0", bus.done_valid); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_rdy;
      logic [REQW-1:0] exp_req;
      int              last = 0;
      reset = 1'b1; step(); reset = 1'b0;
      load_q(8'h00);
      for (int r = 0; r < NREQ; r++) post(r, 2'b00, 4'd0);
      for (int n = 0; n < 5; n++) begin
         exp_rdy = 4'b0001 << (n % 4);
         exp_req = REQW'(n % 4);
         wait_ready();
         n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant%0d: got %b required %b", n, bus.req_ready, exp_rdy); end
         if (n > 0) begin
            n_checks++; if (cyc - last !== SPACING) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d required %0d", n, cyc - last, SPACING); end
         end
         last = cyc;
         step();
         if (n == 4) bus.req_valid = '0;
         wait_done();
         n_checks++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL rr_done_valid%0d: got %b required 1", n, bus.done_valid); end
         n_checks++; if (bus.done_req !== exp_req) begin n_fail++; $display("FAIL rr_done_req%0d: got %0d required %0d", n, bus.done_req, exp_req); end
         n_checks++; if (bus.done_err !== 1'b0) begin n_fail++; $display("FAIL rr_done_err%0d: got %b required 0", n, bus.done_err); end
      end
   endtask

   task automatic test_toggle_ignore();
      load_q(8'h00);
      ignore_jk = 1'b1;
      post(1, 2'b11, 4'd5);
      wait_ready();
      n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL tog_ready: got %b required 0010", bus.req_ready); end
      step();
      bus.req_valid = '0;
      n_checks++; if (bus.bank_j !== 8'h20) begin n_fail++; $display("FAIL tog_bank_j: got %h required 20", bus.bank_j); end
      n_checks++; if (bus.bank_k !== 8'h20) begin n_fail++; $display("FAIL tog_bank_k: got %h required 20", bus.bank_k); end
      wait_done();
      n_checks++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL tog_done_valid: got %b required 1", bus.done_valid); end
      n_checks++; if (bus.done_req !== 2'd1) begin n_fail++; $display("FAIL tog_done_req: got %0d required 1", bus.done_req); end
      n_checks++; if (bus.done_err !== IGN_ERR) begin n_fail++; $display("FAIL tog_done_err: got %b required %b", bus.done_err, IGN_ERR); end
      step();
      ignore_jk = 1'b0;
      n_checks++; if (q_model[5] !== 1'b0) begin n_fail++; $display("FAIL tog_q5: got %b required 0", q_model[5]); end
   endtask

   task automatic test_out_of_range();
      load_q(8'h00);
      post(2, 2'b10, 4'd9);
      wait_ready();
      n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL oor_ready: got %b required 0100", bus.req_ready); end
      step();
      bus.req_valid = '0;
      n_checks++; if (bus.bank_j !== 8'h00) begin n_fail++; $display("FAIL oor_bank_j: got %h required 00", bus.bank_j); end
      n_checks++; if (bus.bank_k !== 8'h00) begin n_fail++; $display("FAIL oor_bank_k: got %h required 00", bus.bank_k); end
      wait_done();
      n_checks++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL oor_done_valid: got %b required 1", bus.done_valid); end
      n_checks++; if (bus.done_req !== 2'd2) begin n_fail++; $display("FAIL oor_done_req: got %0d required 2", bus.done_req); end
      n_checks++; if (bus.done_err !== 1'b1) begin n_fail++; $display("FAIL oor_done_err: got %b required 1", bus.done_err); end
      step();
      n_checks++; if (q_model !== 8'h00) begin n_fail++; $display("FAIL oor_bank: got %h required 00", q_model); end
   endtask

   task automatic test_hold();
      load_q(8'h80);
      post(3, 2'b00, 4'd7);
      wait_ready();
      n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL hold_ready: got %b required 1000", bus.req_ready); end
      step();
      bus.req_valid = '0;
      n_checks++; if (bus.bank_j !== 8'h00) begin n_fail++; $display("FAIL hold_bank_j: got %h required 00", bus.bank_j); end
      n_checks++; if (bus.bank_k !== 8'h00) begin n_fail++; $display("FAIL hold_bank_k: got %h required 00", bus.bank_k); end
      wait_done();
      n_checks++; if (bus.done_valid !== 1'b1) begin n_fail++; $display("FAIL hold_done_valid: got %b required 1", bus.done_valid); end
      n_checks++; if (bus.done_req !== 2'd3) begin n_fail++; $display("FAIL hold_done_req: got %0d required 3", bus.done_req); end
      n_checks++; if (bus.done_err !== 1'b0) begin n_fail++; $display("FAIL hold_done_err: got %b required 0", bus.done_err); end
      step();
      n_checks++; if (q_model[7] !== 1'b1) begin n_fail++; $display("FAIL hold_q7: got %b required 1", q_model[7]); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; step(); reset = 1'b0;
      load_q(8'h00);
      post(0, 2'b10, 4'd0);
      post(1, 2'b10, 4'd0);
      wait_ready();
      n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ready: got %b required 0001", bus.req_ready); end
      step();
      n_checks++; if (bus.bank_j !== 8'h01) begin n_fail++; $display("FAIL mid_issue_j: got %h required 01", bus.bank_j); end
      reset = 1'b1;
      #1;
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b required 0000", bus.req_ready); end
      step();
      reset = 1'b0;
      #1;
      n_checks++; if (bus.bank_j !== 8'h00) begin n_fail++; $display("FAIL mid_abort_j: got %h required 00", bus.bank_j); end
      n_checks++; if (bus.done_valid !== 1'b0) begin n_fail++; $display("FAIL mid_abort_done: got %b required 0", bus.done_valid); end
      n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: got %b required 0001", bus.req_ready); end
      step();
      bus.req_valid = '0;
      wait_done();
      n_checks++; if (bus.done_req !== 2'd0) begin n_fail++; $display("FAIL mid_done_req: got %0d required 0", bus.done_req); end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_set_cmd();
      test_round_robin();
      test_toggle_ignore();
      test_out_of_range();
      test_hold();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1);
   end
endmodule
`default_nettype wire
